// File: rtl/butterfly_r2_pipe.sv
// Four-stage pipelined radix-2 DIT butterfly: out0 = in0 + in1*W, out1 = in0 - in1*W.
// Optional round-half-up in the twiddle product stage: define BUTTERFLY_ROUND_EN.
module butterfly_r2_pipe #(
    parameter int N = 16,
    parameter int Q = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_scale,
    input  logic [N-1:0] i_in0_re,
    input  logic [N-1:0] i_in0_im,
    input  logic [N-1:0] i_in1_re,
    input  logic [N-1:0] i_in1_im,
    input  logic [N-1:0] i_twiddle_re,
    input  logic [N-1:0] i_twiddle_im,
    output logic         o_valid,
    input  logic         i_out_ready,
    output logic [N-1:0] o_out0_re,
    output logic [N-1:0] o_out0_im,
    output logic [N-1:0] o_out1_re,
    output logic [N-1:0] o_out1_im,
    output logic         o_ovf,
    input  logic         i_ovf_clr
);

    typedef logic signed [N-1:0]   word_t;
    typedef logic signed [2*N-1:0] prod_t;
    typedef logic signed [2*N:0]   acc_t;
    typedef logic signed [N+1:0]   twid_t;
    typedef logic signed [N+2:0]   sum_t;

`ifdef BUTTERFLY_ROUND_EN
    localparam acc_t RND = acc_t'(2 ** (Q - 1));
`else
    localparam acc_t RND = acc_t'(0);
`endif

    localparam sum_t SMAX = {4'b0000, {(N-1){1'b1}}};
    localparam sum_t SMIN = {4'b1111, {(N-1){1'b0}}};

    // Returns {saturated, result}.
    function automatic logic [N:0] f_bfly(input word_t a, input twid_t t,
                                          input logic sub, input logic sc);
        sum_t s;
        if (sub) s = {{3{a[N-1]}}, a} - {t[N+1], t};
        else     s = {{3{a[N-1]}}, a} + {t[N+1], t};
        if (sc) s = s >>> 1;
        if (s > SMAX)      return {1'b1, 1'b0, {(N-1){1'b1}}};
        else if (s < SMIN) return {1'b1, 1'b1, {(N-1){1'b0}}};
        else               return {1'b0, s[N-1:0]};
    endfunction

    logic  w_en;
    logic  r_v1, r_v2, r_v3;
    logic  r_sc1, r_sc2, r_sc3;
    word_t r_a_re1, r_a_im1, r_b_re1, r_b_im1, r_w_re1, r_w_im1;
    word_t r_a_re2, r_a_im2, r_a_re3, r_a_im3;
    prod_t r_rr, r_ii, r_ri, r_ir;
    twid_t r_t_re, r_t_im;
    logic [N:0] w_r0_re, w_r0_im, w_r1_re, w_r1_im;
    logic  w_sat;

    assign w_en    = ~o_valid | i_out_ready;
    assign o_ready = w_en;

    assign w_r0_re = f_bfly(r_a_re3, r_t_re, 1'b0, r_sc3);
    assign w_r0_im = f_bfly(r_a_im3, r_t_im, 1'b0, r_sc3);
    assign w_r1_re = f_bfly(r_a_re3, r_t_re, 1'b1, r_sc3);
    assign w_r1_im = f_bfly(r_a_im3, r_t_im, 1'b1, r_sc3);
    assign w_sat   = w_r0_re[N] | w_r0_im[N] | w_r1_re[N] | w_r1_im[N];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0; o_valid <= 1'b0;
            r_sc1 <= 1'b0; r_sc2 <= 1'b0; r_sc3 <= 1'b0;
            r_a_re1 <= '0; r_a_im1 <= '0; r_b_re1 <= '0; r_b_im1 <= '0;
            r_w_re1 <= '0; r_w_im1 <= '0;
            r_a_re2 <= '0; r_a_im2 <= '0; r_a_re3 <= '0; r_a_im3 <= '0;
            r_rr <= '0; r_ii <= '0; r_ri <= '0; r_ir <= '0;
            r_t_re <= '0; r_t_im <= '0;
            o_out0_re <= '0; o_out0_im <= '0; o_out1_re <= '0; o_out1_im <= '0;
        end else if (w_en) begin
            // S1: operand capture
            r_v1    <= i_valid;
            r_sc1   <= i_scale;
            r_a_re1 <= i_in0_re;
            r_a_im1 <= i_in0_im;
            r_b_re1 <= i_in1_re;
            r_b_im1 <= i_in1_im;
            r_w_re1 <= i_twiddle_re;
            r_w_im1 <= i_twiddle_im;
            // S2: products
            r_v2    <= r_v1;
            r_sc2   <= r_sc1;
            r_a_re2 <= r_a_re1;
            r_a_im2 <= r_a_im1;
            r_rr    <= prod_t'(r_b_re1) * prod_t'(r_w_re1);
            r_ii    <= prod_t'(r_b_im1) * prod_t'(r_w_im1);
            r_ri    <= prod_t'(r_b_re1) * prod_t'(r_w_im1);
            r_ir    <= prod_t'(r_b_im1) * prod_t'(r_w_re1);
            // S3: rescale to Q, kept at N+2 bits
            r_v3    <= r_v2;
            r_sc3   <= r_sc2;
            r_a_re3 <= r_a_re2;
            r_a_im3 <= r_a_im2;
            r_t_re  <= twid_t'((acc_t'(r_rr) - acc_t'(r_ii) + RND) >>> Q);
            r_t_im  <= twid_t'((acc_t'(r_ri) + acc_t'(r_ir) + RND) >>> Q);
            // S4: bubbles leave the output registers at their last value
            o_valid <= r_v3;
            if (r_v3) begin
                o_out0_re <= w_r0_re[N-1:0];
                o_out0_im <= w_r0_im[N-1:0];
                o_out1_re <= w_r1_re[N-1:0];
                o_out1_im <= w_r1_im[N-1:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)                    o_ovf <= 1'b0;
        else if (w_en & r_v3 & w_sat) o_ovf <= 1'b1;
        else if (i_ovf_clr)           o_ovf <= 1'b0;
    end

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// Directed-vector bench for butterfly_r2_pipe (N=16, Q=8).
module tb_butterfly_r2_pipe;
    localparam int N = 16;
    localparam int Q = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic i_rst, i_valid, o_ready, i_scale, o_valid, i_out_ready, o_ovf, i_ovf_clr;
    logic signed [N-1:0] i_in0_re, i_in0_im, i_in1_re, i_in1_im, i_twiddle_re, i_twiddle_im;
    logic signed [N-1:0] o_out0_re, o_out0_im, o_out1_re, o_out1_im;

    int assertions = 0;
    int failures   = 0;

    butterfly_r2_pipe #(.N(N), .Q(Q)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_scale(i_scale),
        .i_in0_re(i_in0_re), .i_in0_im(i_in0_im), .i_in1_re(i_in1_re), .i_in1_im(i_in1_im),
        .i_twiddle_re(i_twiddle_re), .i_twiddle_im(i_twiddle_im),
        .o_valid(o_valid), .i_out_ready(i_out_ready),
        .o_out0_re(o_out0_re), .o_out0_im(o_out0_im),
        .o_out1_re(o_out1_re), .o_out1_im(o_out1_im),
        .o_ovf(o_ovf), .i_ovf_clr(i_ovf_clr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic signed [N-1:0] a_re, a_im, b_re, b_im, w_re, w_im,
                         input logic sc);
        i_valid = 1'b1; i_scale = sc;
        i_in0_re = a_re; i_in0_im = a_im; i_in1_re = b_re; i_in1_im = b_im;
        i_twiddle_re = w_re; i_twiddle_im = w_im;
    endtask

    // Presents one sample, then waits (bounded) until it shows up on the output.
    task automatic send_one(input logic signed [N-1:0] a_re, a_im, b_re, b_im, w_re, w_im,
                            input logic sc, output bit got);
        drive(a_re, a_im, b_re, b_im, w_re, w_im, sc);
        tick;
        i_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (o_valid) got = 1'b1;
            else tick;
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_valid = 1'b0; i_scale = 1'b0; i_out_ready = 1'b1; i_ovf_clr = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        i_valid = 1'b0;
        tick; tick;
        i_rst = 1'b0;
        assertions++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL reset o_valid got %b exp 0", o_valid); end
        assertions++;
        if (o_ready !== 1'b1) begin failures++; $display("FAIL reset o_ready got %b exp 1", o_ready); end
        assertions++;
        if ({o_out0_re, o_out0_im, o_out1_re, o_out1_im} !== '0) begin
            failures++; $display("FAIL reset outputs got %0d %0d %0d %0d exp 0", o_out0_re, o_out0_im, o_out1_re, o_out1_im);
        end
        assertions++;
        if (o_ovf !== 1'b0) begin failures++; $display("FAIL reset o_ovf got %b exp 0", o_ovf); end
    endtask

    task automatic test_identity;
        drive(256, 0, 256, 0, 256, 0, 0);
        tick;
        i_valid = 1'b0;
        tick; tick;
        assertions++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL identity early o_valid got %b exp 0", o_valid); end
        tick;
        assertions++;
        if (o_valid !== 1'b1) begin failures++; $display("FAIL identity latency o_valid got %b exp 1", o_valid); end
        assertions++;
        if (o_out0_re !== 16'sd512 || o_out0_im !== 16'sd0) begin
            failures++; $display("FAIL identity out0 got (%0d,%0d) exp (512,0)", o_out0_re, o_out0_im);
        end
        assertions++;
        if (o_out1_re !== 16'sd0 || o_out1_im !== 16'sd0) begin
            failures++; $display("FAIL identity out1 got (%0d,%0d) exp (0,0)", o_out1_re, o_out1_im);
        end
        assertions++;
        if (o_ovf !== 1'b0) begin failures++; $display("FAIL identity o_ovf got %b exp 0", o_ovf); end
        tick;
        assertions++;
        if (o_valid !== 1'b0 || o_out0_re !== 16'sd512) begin
            failures++; $display("FAIL identity bubble got valid=%b out0_re=%0d exp valid=0 out0_re=512", o_valid, o_out0_re);
        end
    endtask

    task automatic test_minus_j;
        bit got;
        send_one(0, 0, 256, 0, 0, -256, 0, got);
        assertions++;
        if (!got) begin failures++; $display("FAIL minus_j timeout got no o_valid exp o_valid"); end
        assertions++;
        if (o_out0_re !== 16'sd0 || o_out0_im !== -16'sd256) begin
            failures++; $display("FAIL minus_j out0 got (%0d,%0d) exp (0,-256)", o_out0_re, o_out0_im);
        end
        assertions++;
        if (o_out1_re !== 16'sd0 || o_out1_im !== 16'sd256) begin
            failures++; $display("FAIL minus_j out1 got (%0d,%0d) exp (0,256)", o_out1_re, o_out1_im);
        end
        tick;
    endtask

    task automatic test_saturation;
        bit got;
        send_one(32767, 0, 256, 0, 256, 0, 0, got);
        assertions++;
        if (!got) begin failures++; $display("FAIL sat timeout got no o_valid exp o_valid"); end
        assertions++;
        if (o_out0_re !== 16'sd32767 || o_out1_re !== 16'sd32511) begin
            failures++; $display("FAIL sat values got %0d %0d exp 32767 32511", o_out0_re, o_out1_re);
        end
        assertions++;
        if (o_ovf !== 1'b1) begin failures++; $display("FAIL sat o_ovf got %b exp 1", o_ovf); end
        for (int k = 0; k < 5; k++) tick;
        assertions++;
        if (o_ovf !== 1'b1) begin failures++; $display("FAIL sat sticky o_ovf got %b exp 1", o_ovf); end
        i_ovf_clr = 1'b1;
        tick;
        i_ovf_clr = 1'b0;
        assertions++;
        if (o_ovf !== 1'b0) begin failures++; $display("FAIL sat clear o_ovf got %b exp 0", o_ovf); end
    endtask

    task automatic test_scale;
        bit got;
        send_one(32767, 0, 256, 0, 256, 0, 1, got);
        assertions++;
        if (!got) begin failures++; $display("FAIL scale timeout got no o_valid exp o_valid"); end
        assertions++;
        if (o_out0_re !== 16'sd16511 || o_out1_re !== 16'sd16255) begin
            failures++; $display("FAIL scale values got %0d %0d exp 16511 16255", o_out0_re, o_out1_re);
        end
        assertions++;
        if (o_ovf !== 1'b0) begin failures++; $display("FAIL scale o_ovf got %b exp 0", o_ovf); end
        tick;
    endtask

    task automatic test_set_wins;
        bit got;
        i_ovf_clr = 1'b1;
        send_one(-32768, 0, 256, 0, 256, 0, 0, got);
        assertions++;
        if (!got) begin failures++; $display("FAIL set_wins timeout got no o_valid exp o_valid"); end
        assertions++;
        if (o_ovf !== 1'b1 || o_out0_re !== -16'sd32512 || o_out1_re !== -16'sd32768) begin
            failures++; $display("FAIL set_wins got ovf=%b out0=%0d out1=%0d exp ovf=1 out0=-32512 out1=-32768", o_ovf, o_out0_re, o_out1_re);
        end
        tick;
        assertions++;
        if (o_ovf !== 1'b0) begin failures++; $display("FAIL set_wins clear o_ovf got %b exp 0", o_ovf); end
        i_ovf_clr = 1'b0;
    endtask

    task automatic test_rounding;
        bit got;
        logic signed [N-1:0] exp0, exp1;
`ifdef BUTTERFLY_ROUND_EN
        exp0 = 16'sd1; exp1 = -16'sd1;
`else
        exp0 = 16'sd0; exp1 = 16'sd0;
`endif
        send_one(0, 0, 1, 0, 128, 0, 0, got);
        assertions++;
        if (!got) begin failures++; $display("FAIL round timeout got no o_valid exp o_valid"); end
        assertions++;
        if (o_out0_re !== exp0 || o_out1_re !== exp1) begin
            failures++; $display("FAIL round values got %0d %0d exp %0d %0d", o_out0_re, o_out1_re, exp0, exp1);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int  sent = 0;
        int  recv = 0;
        bit  seen_low = 1'b0;
        bit  held = 1'b0;
        logic signed [N-1:0] p0r, p0i, p1r, p1i;
        p0r = '0; p0i = '0; p1r = '0; p1i = '0;
        for (int c = 0; c < 200 && recv < 8; c++) begin
            i_out_ready = !(c >= 3 && c <= 10);
            if (sent < 8) drive(16'(100 * sent), 16'(7 * sent), 256, 0, 256, 0, 0);
            else i_valid = 1'b0;
            #1;
            assertions++;
            if (o_ready !== (!o_valid || i_out_ready)) begin
                failures++; $display("FAIL bp o_ready cycle %0d got %b exp %b", c, o_ready, (!o_valid || i_out_ready));
            end
            if (!o_ready) seen_low = 1'b1;
            if (held) begin
                assertions++;
                if (o_valid !== 1'b1 || o_out0_re !== p0r || o_out0_im !== p0i || o_out1_re !== p1r || o_out1_im !== p1i) begin
                    failures++; $display("FAIL bp stable cycle %0d got %0d %0d %0d %0d exp %0d %0d %0d %0d", c, o_out0_re, o_out0_im, o_out1_re, o_out1_im, p0r, p0i, p1r, p1i);
                end
            end
            if (o_valid && i_out_ready) begin
                assertions++;
                if (o_out0_re !== 16'(100 * recv + 256) || o_out0_im !== 16'(7 * recv) ||
                    o_out1_re !== 16'(100 * recv - 256) || o_out1_im !== 16'(7 * recv)) begin
                    failures++; $display("FAIL bp sample %0d got %0d %0d %0d %0d exp %0d %0d %0d %0d", recv, o_out0_re, o_out0_im, o_out1_re, o_out1_im, 100 * recv + 256, 7 * recv, 100 * recv - 256, 7 * recv);
                end
                recv++;
            end
            held = o_valid && !i_out_ready;
            p0r = o_out0_re; p0i = o_out0_im; p1r = o_out1_re; p1i = o_out1_im;
            if (i_valid && o_ready) sent++;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        i_out_ready = 1'b1;
        assertions++;
        if (recv !== 8) begin failures++; $display("FAIL bp count got %0d exp 8", recv); end
        assertions++;
        if (seen_low !== 1'b1) begin failures++; $display("FAIL bp o_ready_drop got %b exp 1", seen_low); end
        tick;
    endtask

    task automatic test_reset_midstream;
        bit got;
        bit stale = 1'b0;
        send_one(32767, 0, 256, 0, 256, 0, 0, got);
        tick;
        for (int k = 0; k < 3; k++) begin
            drive(16'(1000 + k), 0, 256, 0, 256, 0, 0);
            tick;
        end
        i_valid = 1'b0;
        i_rst = 1'b1;
        tick;
        i_rst = 1'b0;
        assertions++;
        if (!got || o_valid !== 1'b0 || o_ovf !== 1'b0) begin
            failures++; $display("FAIL midrst state got seen=%b valid=%b ovf=%b exp seen=1 valid=0 ovf=0", got, o_valid, o_ovf);
        end
        assertions++;
        if ({o_out0_re, o_out0_im, o_out1_re, o_out1_im} !== '0) begin
            failures++; $display("FAIL midrst outputs got %0d %0d %0d %0d exp 0", o_out0_re, o_out0_im, o_out1_re, o_out1_im);
        end
        for (int k = 0; k < 10; k++) begin
            if (o_valid) stale = 1'b1;
            tick;
        end
        assertions++;
        if (stale !== 1'b0) begin failures++; $display("FAIL midrst stale got %b exp 0", stale); end
    endtask

    initial begin
        test_reset;
        test_identity;
        test_minus_j;
        test_saturation;
        test_scale;
        test_set_wins;
        test_rounding;
        test_back_to_back;
        test_reset_midstream;
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
